// File: rtl/zimbo_mem_arbiter.sv
// Two-requester (core / loader) arbiter onto a single-port synchronous memory.
// Optional build macro ZIMBO_ARB_CPU_PRIO_EN: core wins every tie instead of round-robin.
module zimbo_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t r_state;
  logic   r_owner, r_last;
  logic   r_wr_en, r_rd_en, r_cpu_ack, r_ldr_ack, r_rd_ack;
  logic   w_cpu_eff, w_ldr_eff, w_any, w_pick, w_pick_wr, w_addr_ph;

  // The owner's request is still high during DATA, so it is masked out there.
  always_comb begin
    w_cpu_eff = cpu_req & ~((r_state == S_DATA) & ~r_owner);
    w_ldr_eff = ldr_req & ~((r_state == S_DATA) &  r_owner);
    w_any     = (r_state != S_ADDR) & (w_cpu_eff | w_ldr_eff);
`ifdef ZIMBO_ARB_CPU_PRIO_EN
    w_pick    = ~w_cpu_eff;
`else
    w_pick    = (w_cpu_eff & w_ldr_eff) ? ~r_last : w_ldr_eff;
`endif
    w_pick_wr = w_pick ? ldr_wr : cpu_wr;
  end

  // Strobes and acks are decoded one state ahead so they come straight from flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_ldr_ack <= 1'b0;
      r_rd_ack  <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_ldr_ack <= 1'b0;
      r_rd_ack  <= 1'b0;
      case (r_state)
        S_IDLE, S_DATA: begin
          if (r_state == S_DATA) r_last <= r_owner;
          if (w_any) begin
            r_state <= S_ADDR;
            r_owner <= w_pick;
            r_wr_en <= w_pick_wr;
            r_rd_en <= ~w_pick_wr;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADDR: begin
          r_state   <= S_DATA;
          r_cpu_ack <= ~r_owner;
          r_ldr_ack <= r_owner;
          r_rd_ack  <= r_rd_en;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_addr_ph = r_wr_en | r_rd_en;
  assign mem_addr  = w_addr_ph ? (r_owner ? ldr_addr  : cpu_addr)  : '0;
  assign mem_wdata = w_addr_ph ? (r_owner ? ldr_wdata : cpu_wdata) : '0;
  assign mem_wr_en = r_wr_en;
  assign mem_rd_en = r_rd_en;
  assign cpu_ack   = r_cpu_ack;
  assign ldr_ack   = r_ldr_ack;
  assign cpu_rdata = (r_cpu_ack & r_rd_ack) ? mem_rdata : '0;
  assign ldr_rdata = (r_ldr_ack & r_rd_ack) ? mem_rdata : '0;
  assign cpu_stall = cpu_req & ~r_cpu_ack;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;

endmodule

// File: tb/tb_zimbo_mem_arbiter.sv
// Directed bench for zimbo_mem_arbiter with a behavioural synchronous memory.
module tb_zimbo_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_wr = 1'b0, ldr_req = 1'b0, ldr_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0, ldr_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0;
  logic          cpu_ack, cpu_stall, ldr_ack, mem_wr_en, mem_rd_en, busy, owner;
  logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          preload = 1'b1;
  logic [DW-1:0] mem [0:255];
  int            n_cmp = 0;
  int            n_err = 0;

  zimbo_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (preload) mem[8'h10] <= 16'h1234;
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL reset_owner: got %b want 0", owner); end
    n_cmp++; if ({cpu_ack, ldr_ack, mem_wr_en, mem_rd_en} !== 4'b0) begin n_err++;
      $display("FAIL reset_strobes: got %b want 0000", {cpu_ack, ldr_ack, mem_wr_en, mem_rd_en}); end
    n_cmp++; if ({mem_addr, mem_wdata, cpu_rdata, ldr_rdata} !== '0) begin n_err++;
      $display("FAIL reset_data: addr %h wdata %h want 0", mem_addr, mem_wdata); end
  endtask

  task automatic test_cpu_read;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h10; #1;
    n_cmp++; if ({cpu_stall, busy, mem_rd_en} !== 3'b100) begin n_err++;
      $display("FAIL crd_c0: stall/busy/rd %b want 100", {cpu_stall, busy, mem_rd_en}); end
    tick;
    n_cmp++; if ({mem_rd_en, mem_wr_en, cpu_stall, busy} !== 4'b1011) begin n_err++;
      $display("FAIL crd_c1_strobes: rd/wr/stall/busy %b want 1011", {mem_rd_en, mem_wr_en, cpu_stall, busy}); end
    n_cmp++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL crd_c1_addr: got %h want 10", mem_addr); end
    tick;
    n_cmp++; if ({cpu_ack, cpu_stall, mem_rd_en} !== 3'b100) begin n_err++;
      $display("FAIL crd_c2_ack: ack/stall/rd %b want 100", {cpu_ack, cpu_stall, mem_rd_en}); end
    n_cmp++; if (cpu_rdata !== 16'h1234) begin n_err++; $display("FAIL crd_c2_data: got %h want 1234", cpu_rdata); end
    cpu_req = 0;
    tick;
    n_cmp++; if ({cpu_ack, busy} !== 2'b00) begin n_err++; $display("FAIL crd_c3_idle: ack/busy %b want 00", {cpu_ack, busy}); end
  endtask

  task automatic test_ldr_write;
    ldr_req = 1; ldr_wr = 1; ldr_addr = 8'h05; ldr_wdata = 16'hBEEF; #1;
    tick;
    n_cmp++; if ({mem_wr_en, mem_rd_en, owner} !== 3'b101) begin n_err++;
      $display("FAIL lwr_c1: wr/rd/owner %b want 101", {mem_wr_en, mem_rd_en, owner}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {8'h05, 16'hBEEF}) begin n_err++;
      $display("FAIL lwr_c1_bus: addr %h wdata %h want 05 beef", mem_addr, mem_wdata); end
    tick;
    n_cmp++; if ({mem_wr_en, ldr_ack, cpu_ack} !== 3'b010) begin n_err++;
      $display("FAIL lwr_c2: wr/lack/cack %b want 010", {mem_wr_en, ldr_ack, cpu_ack}); end
    n_cmp++; if (ldr_rdata !== 16'h0) begin n_err++; $display("FAIL lwr_c2_rdata: got %h want 0", ldr_rdata); end
    ldr_req = 0; ldr_wr = 0;
    tick;
    ldr_req = 1; #1;
    tick; tick;
    n_cmp++; if ({ldr_ack, ldr_rdata} !== {1'b1, 16'hBEEF}) begin n_err++;
      $display("FAIL lrb_data: ack %b data %h want 1 beef", ldr_ack, ldr_rdata); end
    ldr_req = 0;
    tick;
  endtask

  // Tie with last = loader: core first, loader follows with no IDLE gap.
  task automatic test_tie;
    cpu_req = 1; cpu_addr = 8'h10; ldr_req = 1; ldr_addr = 8'h05; #1;
    tick;
    n_cmp++; if ({owner, mem_addr} !== {1'b0, 8'h10}) begin n_err++;
      $display("FAIL tie_c1: owner %b addr %h want 0 10", owner, mem_addr); end
    tick;
    n_cmp++; if ({cpu_ack, ldr_ack, cpu_rdata} !== {2'b10, 16'h1234}) begin n_err++;
      $display("FAIL tie_c2: cack/lack %b%b data %h want 10 1234", cpu_ack, ldr_ack, cpu_rdata); end
    cpu_req = 0;
    tick;
    n_cmp++; if ({owner, mem_rd_en, mem_addr} !== {2'b11, 8'h05}) begin n_err++;
      $display("FAIL tie_c3: owner %b rd %b addr %h want 1 1 05", owner, mem_rd_en, mem_addr); end
    tick;
    n_cmp++; if ({ldr_ack, ldr_rdata} !== {1'b1, 16'hBEEF}) begin n_err++;
      $display("FAIL tie_c4: ack %b data %h want 1 beef", ldr_ack, ldr_rdata); end
    ldr_req = 0;
    tick;
  endtask

  // Tie with last = core: round-robin gives the loader, priority build gives the core.
  task automatic test_tie_last0;
    logic f;
`ifdef ZIMBO_ARB_CPU_PRIO_EN
    f = 1'b0;
`else
    f = 1'b1;
`endif
    cpu_req = 1; #1; tick; tick; cpu_req = 0; tick;
    cpu_req = 1; ldr_req = 1; #1;
    tick;
    n_cmp++; if (owner !== f) begin n_err++; $display("FAIL tie0_c1_owner: got %b want %b", owner, f); end
    tick;
    n_cmp++; if ({cpu_ack, ldr_ack} !== {~f, f}) begin n_err++;
      $display("FAIL tie0_c2: cack/lack %b%b want %b%b", cpu_ack, ldr_ack, ~f, f); end
    if (f) ldr_req = 0; else cpu_req = 0;
    tick; tick;
    n_cmp++; if ({cpu_ack, ldr_ack} !== {f, ~f}) begin n_err++;
      $display("FAIL tie0_c4: cack/lack %b%b want %b%b", cpu_ack, ldr_ack, f, ~f); end
    cpu_req = 0; ldr_req = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    cpu_req = 1; cpu_addr = 8'h10; #1;
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if ({cpu_ack, mem_rd_en} !== {(c % 3) == 2, (c % 3) == 1}) begin n_err++;
        $display("FAIL b2b_c%0d: ack/rd %b%b want %b%b", c, cpu_ack, mem_rd_en, (c % 3) == 2, (c % 3) == 1); end
      if (c % 3 == 2) begin
        n_cmp++; if (cpu_rdata !== 16'h1234) begin n_err++; $display("FAIL b2b_data_c%0d: got %h want 1234", c, cpu_rdata); end
      end
      if (c == 11) cpu_req = 0;
      tick;
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
  endtask

  // Both requesters held: one access per 2 cycles, alternating owners.
  task automatic test_alternate;
    logic f;
`ifdef ZIMBO_ARB_CPU_PRIO_EN
    f = 1'b0;
`else
    f = 1'b1;
`endif
    cpu_req = 1; ldr_req = 1; #1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c % 2 == 0) begin
        n_cmp++; if ({cpu_ack, ldr_ack} !== ((f ^ (c == 4)) ? 2'b01 : 2'b10)) begin n_err++;
          $display("FAIL alt_c%0d: cack/lack %b%b first %b", c, cpu_ack, ldr_ack, f); end
      end
      if (c == 4) begin if (f) cpu_req = 0; else ldr_req = 0; end
      if (c == 6) begin cpu_req = 0; ldr_req = 0; end
    end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL alt_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    ldr_req = 1; ldr_wr = 1; ldr_addr = 8'h05; ldr_wdata = 16'h1111; #1;
    tick;
    n_cmp++; if (mem_wr_en !== 1'b1) begin n_err++; $display("FAIL rmid_wr_before: got %b want 1", mem_wr_en); end
    #1 reset_n = 0; #1;
    n_cmp++; if ({mem_wr_en, busy, ldr_ack, owner} !== 4'b0) begin n_err++;
      $display("FAIL rmid_async: wr/busy/ack/owner %b want 0000", {mem_wr_en, busy, ldr_ack, owner}); end
    n_cmp++; if (mem_addr !== 8'h0) begin n_err++; $display("FAIL rmid_addr: got %h want 00", mem_addr); end
    tick;
    ldr_req = 0; ldr_wr = 0; reset_n = 1; #1;
    tick;
    n_cmp++; if ({ldr_ack, busy} !== 2'b00) begin n_err++; $display("FAIL rmid_noack: ack/busy %b want 00", {ldr_ack, busy}); end
    cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h05; #1;
    tick; tick;
    n_cmp++; if ({cpu_ack, cpu_rdata} !== {1'b1, 16'hBEEF}) begin n_err++;
      $display("FAIL rmid_mem: ack %b data %h want 1 beef", cpu_ack, cpu_rdata); end
    cpu_req = 0;
    tick;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 preload = 0;
    test_reset;
    reset_n = 1;
    test_cpu_read;
    test_ldr_write;
    test_tie;
    test_tie_last0;
    test_back_to_back;
    test_alternate;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
